// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one single-cycle ALU between two requesters. A granted request has its
// op/operands registered onto the ALU inputs (ISSUE). The ALU result is captured
// at the end of ISSUE and returned to the granted requester over a valid/ready
// response channel (RESP). Only one transaction is in flight at a time.
//
// Configuration macro:
//   ALU_ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate
//                           undefined -> fixed priority, requester 0 wins
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready     request handshake (ready is combinational,
//                               only in IDLE, only for the granted requester)
//   reqN_op, reqN_a, reqN_b     operation code and operands
//   respN_valid / respN_ready   response handshake
//   respN_result                captured ALU result (same value on both ports)
//   alu_operation, alu_a, alu_b registered drive to the shared ALU
//   alu_result                  combinational ALU output
//   busy                        high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic            resp0_valid,
    input  logic            resp0_ready,
    output logic [XLEN-1:0] resp0_result,

    output logic            resp1_valid,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp1_result,

    output logic [OPW-1:0]  alu_operation,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result,

    output logic            busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]      state_q,  state_d;
    logic            grant_q,  grant_d;   // index of the requester being served
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [XLEN-1:0] alu_a_q,  alu_a_d;
    logic [XLEN-1:0] alu_b_q,  alu_b_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            grant_any;           // a grant happens this cycle
    logic            grant_idx;           // which requester wins it

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
`ifdef ALU_ARB_ROUND_ROBIN_EN
    // rr_q names the requester that wins the next tie; it always points at
    // the requester that was not granted most recently.
    logic rr_q, rr_d;

    always_comb begin
        grant_idx = (req0_valid && req1_valid) ? rr_q : req1_valid;
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_any) begin
            rr_d = ~grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: requester 1 is chosen only when requester 0 is idle.
    always_comb begin
        grant_idx = req1_valid && !req0_valid;
    end
`endif

    assign grant_any  = (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = grant_any && !grant_idx;
    assign req1_ready = grant_any &&  grant_idx;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold value first so no path can infer a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    state_d  = ST_ISSUE;
                    grant_d  = grant_idx;
                    alu_op_d = grant_idx ? req1_op : req0_op;
                    alu_a_d  = grant_idx ? req1_a  : req0_a;
                    alu_b_d  = grant_idx ? req1_b  : req0_b;
                end
            end
            ST_ISSUE: begin
                // ALU inputs have been stable for the whole cycle; sample it.
                result_d = alu_result;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (grant_q ? resp1_ready : resp0_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: datapath registers are reset too, because the ALU inputs and the
        // result are visible on ports and must read 0 out of reset.
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            grant_q  <= grant_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign alu_operation = alu_op_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;

    assign resp0_valid   = (state_q == ST_RESP) && !grant_q;
    assign resp1_valid   = (state_q == ST_RESP) &&  grant_q;
    assign resp0_result  = result_q;
    assign resp1_result  = result_q;

    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed bench for alu_share_arbiter. A stub ALU (ADD/SUB/XOR, anything else
// returns 0xDEADBEEF) sits on the alu_* ports. A table of single transactions
// is replayed on alternating requesters, followed by hand-written sequences for
// simultaneous requests, response backpressure and reset during ISSUE.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int XLEN = 32;
    localparam int OPW  = 4;

    localparam logic [OPW-1:0] ALU_ADD = 4'h0;
    localparam logic [OPW-1:0] ALU_SUB = 4'h1;
    localparam logic [OPW-1:0] ALU_XOR = 4'h4;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [OPW-1:0]  req0_op, req1_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [XLEN-1:0] resp0_result, resp1_result;
    logic [OPW-1:0]  alu_operation;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic            busy;

    int n_total  = 0;
    int n_passed = 0;

    alu_share_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_op       (req0_op),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_op       (req1_op),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .resp0_valid   (resp0_valid),
        .resp0_ready   (resp0_ready),
        .resp0_result  (resp0_result),
        .resp1_valid   (resp1_valid),
        .resp1_ready   (resp1_ready),
        .resp1_result  (resp1_result),
        .alu_operation (alu_operation),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_result    (alu_result),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub ALU: unknown codes return a marker so pass-through is observable.
    always_comb begin
        case (alu_operation)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_XOR: alu_result = alu_a ^ alu_b;
            default: alu_result = 32'hDEADBEEF;
        endcase
    end

    typedef struct {
        logic            port;
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // Single transactions: port, op, a, b, expected result.
        vecs[0] = '{1'b0, ALU_ADD, 32'd5,        32'd3,        32'd8};
        vecs[1] = '{1'b1, ALU_SUB, 32'd10,       32'd4,        32'd6};
        vecs[2] = '{1'b0, ALU_XOR, 32'h000000F0, 32'h0000000F, 32'h000000FF};
        vecs[3] = '{1'b1, 4'hF,    32'hFFFFFFFF, 32'h80000000, 32'hDEADBEEF};
        vecs[4] = '{1'b0, ALU_ADD, 32'hFFFFFFFF, 32'd1,        32'h00000000};
        vecs[5] = '{1'b1, ALU_SUB, 32'd0,        32'd1,        32'hFFFFFFFF};
        vecs[6] = '{1'b0, 4'hC,    32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF};

        clear_inputs();
        rst = 1'b1;
        #2;
        check("rst_busy",    busy,          0);
        check("rst_ready0",  req0_ready,    0);
        check("rst_ready1",  req1_ready,    0);
        check("rst_rvalid0", resp0_valid,   0);
        check("rst_rvalid1", resp1_valid,   0);
        check("rst_alu_op",  alu_operation, 0);
        check("rst_alu_a",   alu_a,         0);
        check("rst_alu_b",   alu_b,         0);
        check("rst_result",  resp0_result,  0);
        next_cycle();
        rst = 1'b0;

        // ---------------- table-driven single transactions ----------------
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].port) begin
                req1_valid = 1'b1; req1_op = vecs[i].op; req1_a = vecs[i].a; req1_b = vecs[i].b;
                resp1_ready = 1'b1;
            end else begin
                req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
                resp0_ready = 1'b1;
            end
            #1;
            check($sformatf("v%0d_ready0", i), req0_ready, !vecs[i].port);
            check($sformatf("v%0d_ready1", i), req1_ready, vecs[i].port);
            check($sformatf("v%0d_idle", i),   busy,       0);
            next_cycle();
            clear_inputs();
            resp0_ready = 1'b1;
            resp1_ready = 1'b1;
            check($sformatf("v%0d_alu_op", i), alu_operation, vecs[i].op);
            check($sformatf("v%0d_alu_a", i),  alu_a,         vecs[i].a);
            check($sformatf("v%0d_alu_b", i),  alu_b,         vecs[i].b);
            check($sformatf("v%0d_busy", i),   busy,          1);
            check($sformatf("v%0d_early_rv", i), resp0_valid | resp1_valid, 0);
            next_cycle();
            check($sformatf("v%0d_rvalid0", i), resp0_valid, !vecs[i].port);
            check($sformatf("v%0d_rvalid1", i), resp1_valid, vecs[i].port);
            check($sformatf("v%0d_result", i),
                  vecs[i].port ? resp1_result : resp0_result, vecs[i].exp);
            next_cycle();
            check($sformatf("v%0d_done", i), busy, 0);
            clear_inputs();
        end

        // ---------------- simultaneous requests ----------------
        apply_reset();
        req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'd10;   req0_b = 32'd4;
        req1_valid = 1'b1; req1_op = ALU_XOR; req1_a = 32'hF0;   req1_b = 32'h0F;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int  phase;
            bit  win;
            phase = k % 3;
            win   = RR_EN ? bit'((k / 3) % 2) : 1'b0;
            #1;
            if (phase == 0) begin
                check($sformatf("both_c%0d_ready0", k), req0_ready, !win);
                check($sformatf("both_c%0d_ready1", k), req1_ready, win);
            end else begin
                check($sformatf("both_c%0d_ready0", k), req0_ready, 0);
                check($sformatf("both_c%0d_ready1", k), req1_ready, 0);
            end
            if (phase == 2) begin
                check($sformatf("both_c%0d_rvalid0", k), resp0_valid, !win);
                check($sformatf("both_c%0d_rvalid1", k), resp1_valid, win);
                check($sformatf("both_c%0d_result", k), resp0_result,
                      win ? 32'h000000FF : 32'd6);
            end
            next_cycle();
        end
        clear_inputs();

        // ---------------- response backpressure ----------------
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd3;
        #1;
        check("bp_grant0", req0_ready, 1);
        next_cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 32'd10; req1_b = 32'd4;
        resp1_ready = 1'b1;
        #1;
        check("bp_issue_ready1", req1_ready, 0);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_w%0d_rvalid0", i), resp0_valid,  1);
            check($sformatf("bp_w%0d_result", i),  resp0_result, 32'd8);
            check($sformatf("bp_w%0d_busy", i),    busy,         1);
            check($sformatf("bp_w%0d_ready1", i),  req1_ready,   0);
            next_cycle();
        end
        resp0_ready = 1'b1;
        #1;
        check("bp_release_rvalid0", resp0_valid, 1);
        check("bp_release_ready1",  req1_ready,  0);
        next_cycle();
        resp0_ready = 1'b0;
        #1;
        check("bp_grant1", req1_ready, 1);
        next_cycle();
        req1_valid = 1'b0;
        next_cycle();
        #1;
        check("bp_rvalid1", resp1_valid,  1);
        check("bp_result1", resp1_result, 32'd6);
        check("bp_rvalid0_low", resp0_valid, 0);
        next_cycle();
        check("bp_done", busy, 0);
        clear_inputs();

        // ---------------- reset during ISSUE ----------------
        req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd3;
        resp0_ready = 1'b1;
        next_cycle();
        req0_valid = 1'b0;
        check("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_busy",    busy,          0);
        check("mid_rvalid0", resp0_valid,   0);
        check("mid_alu_op",  alu_operation, 0);
        check("mid_alu_a",   alu_a,         0);
        check("mid_alu_b",   alu_b,         0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mid_after%0d_rvalid", i), resp0_valid | resp1_valid, 0);
            check($sformatf("mid_after%0d_busy", i),   busy, 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
